// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium stream controller.
//   state_t          controller state encoding
//   COND_*           FIFO fill-state encoding reported by both byte FIFOs
//   WARMUP_STEPS_DEF core steps between key/IV load and first keystream use
package trivium_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WARMUP,
        ST_FETCH,
        ST_WAIT_STB,
        ST_EMIT
    } state_t;

    localparam logic [1:0] COND_EMPTY = 2'b00;
    localparam logic [1:0] COND_PART  = 2'b10;
    localparam logic [1:0] COND_FULL  = 2'b11;

    // 1152 warm-up bits at 8 bits per core step
    localparam int WARMUP_STEPS_DEF = 144;

endpackage

// File: rtl/trivium_stream_ctrl.sv
// Session controller for byte-wide Trivium encryption between two byte FIFOs.
// Loads and warms up the keystream core, then moves plaintext bytes from the
// input FIFO through an XOR with the keystream into the output FIFO.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   start, stop     one-cycle session start / stop pulses
//   in_dout         input FIFO data (registered by the FIFO after its strobe)
//   in_read_stb     input FIFO read strobe (timing is fixed, not consumed)
//   in_condition    input FIFO fill state
//   in_read         input FIFO read request
//   out_din         ciphertext byte, out_write qualifies it
//   out_write       output FIFO write enable
//   out_condition   output FIFO fill state
//   core_load       load key/IV into the core
//   core_step       advance the core by one byte
//   core_ks         current keystream byte from the core
//   busy            session active (state not IDLE)
//   ready           warm-up complete, session running
//   byte_count      ciphertext bytes emitted this session (wraps)
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no session; waiting for start
// LOAD      | key/IV loaded into the core this cycle
// WARMUP    | core stepped every cycle, discarding keystream
// FETCH     | request a byte when input has data and output has room
// WAIT_STB  | FIFO presents the byte; it is registered at cycle end
// EMIT      | write plaintext ^ keystream, consume the keystream byte
module trivium_stream_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP_STEPS = WARMUP_STEPS_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       in_dout,
    input  logic             in_read_stb,
    input  logic [1:0]       in_condition,
    output logic             in_read,
    output logic [7:0]       out_din,
    output logic             out_write,
    input  logic [1:0]       out_condition,
    output logic             core_load,
    output logic             core_step,
    input  logic [7:0]       core_ks,
    output logic             busy,
    output logic             ready,
    output logic [CNT_W-1:0] byte_count
);

    state_t           r_state;
    logic             r_ready;
    logic             r_stop_pend;
    logic [7:0]       r_warm_cnt;
    logic [CNT_W-1:0] r_byte_count;

    logic             w_can_read;
    logic             w_unused_stb;

    // The FIFO always answers a request one cycle later, so the strobe
    // carries no information the state sequence does not already have.
    assign w_unused_stb = in_read_stb;

    assign w_can_read = (in_condition != COND_EMPTY) &&
                        (out_condition != COND_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_warm_cnt   <= 8'd0;
            r_byte_count <= '0;
        end else begin
            // A stop is only remembered here; it is acted on at FETCH so a
            // byte already requested from the FIFO always completes.
            if (stop && (r_state != ST_IDLE)) begin
                r_stop_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_byte_count <= '0;
                        r_stop_pend  <= 1'b0;
                        r_warm_cnt   <= 8'd0;
                    end
                end
                ST_LOAD: begin
                    // Terminal count 0 is reached on the last warm-up cycle
                    r_warm_cnt <= 8'(WARMUP_STEPS - 1);
                    r_state    <= ST_WARMUP;
                end
                ST_WARMUP: begin
                    if (r_warm_cnt == 8'd0) begin
                        r_state <= ST_FETCH;
                        r_ready <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt - 8'd1;
                    end
                end
                ST_FETCH: begin
                    if (r_stop_pend) begin
                        r_state     <= ST_IDLE;
                        r_ready     <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end else if (w_can_read) begin
                        r_state <= ST_WAIT_STB;
                    end
                end
                ST_WAIT_STB: begin
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    r_byte_count <= r_byte_count + 1'b1;
                    r_state      <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_read    = (r_state == ST_FETCH) && !r_stop_pend && w_can_read;
    assign out_write  = (r_state == ST_EMIT);
    assign core_load  = (r_state == ST_LOAD);
    assign core_step  = (r_state == ST_WARMUP) || (r_state == ST_EMIT);
    assign out_din    = (r_state == ST_EMIT) ? (in_dout ^ core_ks) : 8'h00;
    assign busy       = (r_state != ST_IDLE);
    assign ready      = r_ready;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
module tb_trivium_stream_ctrl;

    localparam int WS   = 144;
    localparam int CW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    in_dout = 8'h00;
    logic          in_read_stb = 1'b0;
    logic [1:0]    in_condition = 2'b00;
    logic          in_read;
    logic [7:0]    out_din;
    logic          out_write;
    logic [1:0]    out_condition = 2'b10;
    logic          core_load;
    logic          core_step;
    logic [7:0]    core_ks;
    logic          busy;
    logic          ready;
    logic [CW-1:0] byte_count;

    trivium_stream_ctrl #(.WARMUP_STEPS(WS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_dout(in_dout), .in_read_stb(in_read_stb), .in_condition(in_condition),
        .in_read(in_read), .out_din(out_din), .out_write(out_write),
        .out_condition(out_condition), .core_load(core_load), .core_step(core_step),
        .core_ks(core_ks), .busy(busy), .ready(ready), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- environment: FIFOs, core model, scoreboard ----------
    logic [7:0] ks_byte [0:4095];
    int         step_idx = 0;
    int         sess_idx = 0;
    int         cyc      = 0;
    int         n_steps  = 0;
    bit         force_full = 1'b0;
    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int         rd_log[$];
    int         wr_log[$];
    logic [7:0] ct_log[$];

    assign core_ks = ks_byte[step_idx];

    always @(negedge clk) begin
        in_condition  = (in_q.size() == 0) ? 2'b00 : ((in_q.size() >= 256) ? 2'b11 : 2'b10);
        out_condition = force_full ? 2'b11 : 2'b10;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_read_stb <= 1'b0;
            in_dout     <= 8'h00;
            step_idx    <= 0;
            sess_idx    <= 0;
            in_q.delete();
            exp_q.delete();
        end else begin
            cyc++;
            in_read_stb <= in_read;
            if (in_read_stb) begin
                if (in_q.size() > 0) in_dout <= in_q.pop_front();
                else                 in_dout <= 8'h00;
            end
            if (core_load)      step_idx <= 0;
            else if (core_step) step_idx <= step_idx + 1;
            if (core_step) n_steps++;
            if (core_load) sess_idx <= 0;
            if (in_read) begin
                rd_log.push_back(cyc);
                chk("read_needs_input", {31'd0, in_condition != 2'b00}, 1);
                chk("read_needs_room", {31'd0, out_condition != 2'b11}, 1);
            end
            if (core_step && ready) chk("step_only_in_emit", {31'd0, out_write}, 1);
            if (out_write) begin
                wr_log.push_back(cyc);
                ct_log.push_back(out_din);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {24'd0, out_din}, 32'hFFFF_FFFF);
                end else begin
                    // i-th byte of a session uses keystream byte WS+i
                    chk("scoreboard_ct", {24'd0, out_din},
                        {24'd0, exp_q.pop_front() ^ ks_byte[WS + sess_idx]});
                end
                if (!core_load) sess_idx <= sess_idx + 1;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        in_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        ct_log.delete();
    endtask

    typedef struct {
        logic [7:0] pt;
        logic [7:0] ks;
        logic [7:0] ct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int loads, steps, load_first, ready_first, n, s0, total;

        vecs[0] = '{8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{8'h55, 8'h3C, 8'h69};
        vecs[2] = '{8'hFF, 8'h0F, 8'hF0};
        vecs[3] = '{8'h12, 8'h34, 8'h26};
        for (int i = 0; i < 4096; i++) ks_byte[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) ks_byte[WS + i] = vecs[i].ks;

        // ---- reset values
        repeat (3) tick();
        chk("rst_in_read", {31'd0, in_read}, 0);
        chk("rst_out_write", {31'd0, out_write}, 0);
        chk("rst_core_load", {31'd0, core_load}, 0);
        chk("rst_core_step", {31'd0, core_step}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_out_din", {24'd0, out_din}, 0);
        chk("rst_byte_count", {24'd0, byte_count}, 0);
        rst = 1'b1;
        tick();

        // ---- start, load and warm-up timing
        clear_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        loads = 0; steps = 0; load_first = -1; ready_first = -1;
        for (int c = 1; c <= 150; c++) begin
            if (core_load) begin
                loads++;
                if (load_first < 0) load_first = c;
            end
            if (core_step) steps++;
            if (ready && ready_first < 0) ready_first = c;
            if (c < 150) tick();
        end
        chk("load_cycles", loads, 1);
        chk("load_first_cycle", load_first, 1);
        chk("warmup_steps", steps, WS);
        chk("ready_cycle", ready_first, WS + 2);
        chk("no_read_when_empty", rd_log.size(), 0);

        // ---- table vectors: three preloaded bytes
        clear_logs();
        for (int i = 0; i < 3; i++) push_byte(vecs[i].pt);
        n = 0;
        while (ct_log.size() < 3 && n < 40) begin tick(); n++; end
        chk("t3_writes", ct_log.size(), 3);
        if (ct_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("vec_ct", {24'd0, ct_log[i]}, {24'd0, vecs[i].ct});
                chk("vec_latency", wr_log[i] - rd_log[i], 2);
                if (i > 0) chk("read_spacing", rd_log[i] - rd_log[i-1], 3);
            end
        end
        tick();
        chk("count_after_3", {24'd0, byte_count}, 3);

        // ---- input empty for 20 cycles, then one byte
        clear_logs();
        s0 = n_steps;
        repeat (20) tick();
        chk("idle_reads", rd_log.size(), 0);
        chk("idle_writes", wr_log.size(), 0);
        chk("idle_steps", n_steps - s0, 0);
        push_byte(vecs[3].pt);
        n = 0;
        while (ct_log.size() < 1 && n < 20) begin tick(); n++; end
        chk("late_byte_written", ct_log.size(), 1);
        if (ct_log.size() == 1) begin
            chk("late_byte_ct", {24'd0, ct_log[0]}, {24'd0, vecs[3].ct});
            chk("late_byte_latency", wr_log[0] - rd_log[0], 2);
        end

        // ---- output full holds FETCH, release resumes without losing keystream
        force_full = 1'b1;
        tick();
        clear_logs();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        repeat (15) tick();
        chk("full_no_reads", rd_log.size(), 0);
        force_full = 1'b0;
        n = 0;
        while (ct_log.size() < 2 && n < 30) begin tick(); n++; end
        chk("full_release_writes", ct_log.size(), 2);

        // ---- randomized traffic, crosses byte_count rollover
        total = 6;
        for (int i = 0; i < 260; i++) begin
            push_byte(8'($urandom));
            total++;
            repeat ($urandom_range(0, 4)) tick();
            if ($urandom_range(0, 7) == 0) force_full = ~force_full;
        end
        force_full = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || busy && !(in_q.size() == 0 && !out_write && !in_read_stb)) && n < 2000) begin
            tick(); n++;
        end
        repeat (3) tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rollover_count", {24'd0, byte_count}, total % 256);

        // ---- stop during WAIT_STB
        clear_logs();
        push_byte(8'h3A);
        push_byte(8'hC7);
        n = 0;
        while (rd_log.size() == 0 && n < 20) begin tick(); n++; end
        chk("stop_read_seen", rd_log.size(), 1);
        stop = 1'b1;           // now in WAIT_STB
        tick();
        stop = 1'b0;
        chk("stop_emit_completes", {31'd0, out_write}, 1);
        tick();
        chk("stop_fetch_busy", {31'd0, busy}, 1);
        chk("stop_fetch_no_read", {31'd0, in_read}, 0);
        tick();
        chk("stop_idle_busy", {31'd0, busy}, 0);
        chk("stop_idle_ready", {31'd0, ready}, 0);
        chk("stop_one_write", ct_log.size(), 1);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_load", {31'd0, core_load}, 1);
        chk("restart_count_clear", {24'd0, byte_count}, 0);
        n = 1;
        while (!ready && n < 200) begin tick(); n++; end
        chk("restart_ready_cycle", n, WS + 2);
        n = 0;
        while (ct_log.size() < 2 && n < 20) begin tick(); n++; end
        chk("restart_leftover_written", ct_log.size(), 2);
        tick();
        chk("restart_count", {24'd0, byte_count}, 1);

        // ---- reset during EMIT
        push_byte(8'h5E);
        n = 0;
        while (!out_write && n < 20) begin tick(); n++; end
        chk("emit_reached", {31'd0, out_write}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_write", {31'd0, out_write}, 0);
        chk("arst_core_step", {31'd0, core_step}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ready", {31'd0, ready}, 0);
        chk("arst_out_din", {24'd0, out_din}, 0);
        chk("arst_byte_count", {24'd0, byte_count}, 0);
        chk("arst_in_read", {31'd0, in_read}, 0);
        chk("arst_core_load", {31'd0, core_load}, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, busy}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_load", {31'd0, core_load}, 1);
        chk("post_rst_busy", {31'd0, busy}, 1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trivium_stream_ctrl.md
# trivium_stream_ctrl

Session controller that sequences byte-wide Trivium encryption between two 256-entry byte FIFOs. Loads and warms up an 8-bit-per-step Trivium keystream core, then drains the plaintext FIFO one byte at a time, XORs each byte with the keystream and writes the result into the ciphertext FIFO. Sits between the input FIFO, the keystream core and the output FIFO. It is the only reader of the input FIFO and the only writer of the output FIFO.

## Interface
Parameters:
- WARMUP_STEPS, 144: core steps after load before keystream is used (1152 bits / 8).
- CNT_W, 16: width of byte_count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a session. Key/IV are already stable at the core.
- stop  in  1  one-cycle pulse; ends the session after the byte in flight.
- in_dout  in  8  input FIFO data.
- in_read_stb  in  1  input FIFO read strobe.
- in_condition  in  2  input FIFO state: 00 empty, 10 partial, 11 full.
- in_read  out  1  input FIFO read request.
- out_din  out  8  ciphertext byte to output FIFO.
- out_write  out  1  output FIFO write enable.
- out_condition  in  2  output FIFO state, same encoding.
- core_load  out  1  loads key/IV into core state.
- core_step  out  1  advances core by 8 bits.
- core_ks  in  8  current keystream byte; combinational from core state.
- busy  out  1  state != IDLE.
- ready  out  1  warm-up complete, session running.
- byte_count  out  CNT_W  bytes emitted this session.

## Operation
- States: IDLE, LOAD, WARMUP, FETCH, WAIT_STB, EMIT.
- IDLE: start=1 -> LOAD; clear byte_count, stop_pend, warm-up counter. start is ignored in all other states.
- LOAD: core_load=1 for exactly one cycle -> WARMUP.
- WARMUP: core_step=1 every cycle. After WARMUP_STEPS cycles -> FETCH, and ready is set.
- FETCH: stop_pend=1 -> IDLE, ready cleared. Otherwise, if in_condition!=00 and out_condition!=11, in_read=1 for that cycle -> WAIT_STB. Otherwise remain in FETCH with no request.
- WAIT_STB: in_read_stb is expected high. The FIFO registers in_dout at the end of this cycle. Unconditionally -> EMIT.
- EMIT: out_write=1, out_din=in_dout^core_ks, core_step=1, byte_count+1 (wraps modulo 2^CNT_W) -> FETCH.
- stop: a pulse in any non-IDLE state sets stop_pend. Session ends at the next FETCH, so an in-flight byte always completes. A stop pulse during WARMUP takes effect at the first FETCH, after warm-up.
- The core is never stepped except in WARMUP and EMIT. Each keystream byte is used exactly once.
- in_read, out_write, core_load and core_step are decoded from the registered state only; there are no combinational paths from inputs to these outputs other than the FETCH-qualified in_read.

## Timing
- Reset values: state IDLE; in_read, out_write, core_load, core_step, busy, ready all 0; out_din 0; byte_count 0.
- start sampled at edge 0: LOAD in cycle 1, WARMUP in cycles 2 to WARMUP_STEPS+1, FETCH with ready=1 in cycle WARMUP_STEPS+2.
- Byte latency: in_read in cycle t, in_read_stb in t+1, out_write in t+2. Throughput is 1 byte per 3 cycles.
- Input empty: FETCH idles indefinitely with no read pulses.
- Output full: FETCH idles. The controller is the sole writer, so full cannot arise between FETCH and EMIT.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The FIFOs share rst, so no read is left pending.
- byte_count rolls over from 0xFFFF to 0x0000 without affecting operation.

## Structure
- trivium_pkg holds:
  - the state enum;
  - condition constants COND_EMPTY=2'b00, COND_PART=2'b10, COND_FULL=2'b11;
  - the default WARMUP_STEPS constant.
- There is no sub-module. The warm-up counter is an 8-bit register within the block. FIFOs and core are instantiated by the parent.

## Test plan
- Reset, then start with WARMUP_STEPS=144: core_load high in cycle 1 only; core_step high for exactly 144 cycles; ready rises in cycle 146.
- Input FIFO preloaded with 0x00,0x55,0xFF; core_ks model = 0xA5,0x3C,0x0F: output FIFO receives 0xA5,0x69,0xF0; byte_count=3; in_read pulses spaced 3 cycles apart.
- Input FIFO empty for 20 cycles after ready: no in_read, out_write or core_step. Then one byte 0x12 is written with core_ks 0x34: out_din 0x26 written two cycles after in_read.
- out_condition forced to 11 with input non-empty: FETCH holds with no reads. Released: normal flow resumes with no lost keystream byte.
- stop pulsed in WAIT_STB: the byte completes in EMIT, then IDLE next cycle, ready=0, busy=0. A second start re-runs LOAD/WARMUP and clears byte_count.
- rst asserted during EMIT: all outputs 0 asynchronously; state IDLE after release; start is accepted normally.
